// File: rtl/ids_input_arbiter_pkg.sv
// Shared ids definitions: arbiter state encodings, counter width and round-robin helper.
package ids_input_arbiter_pkg;

  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned CNT_WIDTH = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FWD  = 1'b1
  } arb_state_t;

  typedef enum logic {
    SUB_HDR  = 1'b0,
    SUB_BODY = 1'b1
  } pkt_sub_t;

  // The port that did not win last time is preferred; otherwise take whichever has data.
  function automatic logic rr_pick(input logic last_grant, input logic ne0, input logic ne1);
    logic pick;
    if (last_grant) pick = ne0 ? 1'b0 : 1'b1;
    else            pick = ne1 ? 1'b1 : 1'b0;
    return pick;
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: head word is visible on dout whenever not empty.
module fallthrough_small_fifo #(
  parameter int unsigned WIDTH          = 72,
  parameter int unsigned MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             empty
);

  localparam int unsigned AW    = MAX_DEPTH_BITS;
  localparam int unsigned CW    = MAX_DEPTH_BITS + 1;
  localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    depth;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   depth <= depth + CW'(1);
        2'b01:   depth <= depth - CW'(1);
        default: depth <= depth;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  assign dout        = mem[rd_ptr];
  assign empty       = (depth == '0);
  assign full        = (depth == CW'(DEPTH));
  assign nearly_full = (depth >= CW'(DEPTH - 1));

endmodule

// File: rtl/ids_input_arbiter.sv
// Two-port packet-level round-robin arbiter merging upstream streams toward the ids block.
module ids_input_arbiter
  import ids_input_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned FIFO_DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [DATA_WIDTH-1:0] in0_data,
  input  logic [CTRL_WIDTH-1:0] in0_ctrl,
  input  logic                  in0_wr,
  output logic                  in0_rdy,

  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic [CTRL_WIDTH-1:0] in1_ctrl,
  input  logic                  in1_wr,
  output logic                  in1_rdy,

  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,

  input  logic                  arb_enable,
  output logic [CNT_WIDTH-1:0]  pkt_cnt0,
  output logic [CNT_WIDTH-1:0]  pkt_cnt1,
  output logic                  busy
);

  localparam int unsigned FIFO_WIDTH = CTRL_WIDTH + DATA_WIDTH;

  logic [FIFO_WIDTH-1:0] fifo_dout0;
  logic [FIFO_WIDTH-1:0] fifo_dout1;
  logic                  empty0;
  logic                  empty1;
  logic                  nearly_full0;
  logic                  nearly_full1;
  logic                  full0;
  logic                  full1;
  logic                  rd_en0;
  logic                  rd_en1;

  arb_state_t            state;
  pkt_sub_t              sub;
  logic                  grant;
  logic                  last_grant;

  logic [FIFO_WIDTH-1:0] head;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_empty;
  logic                  pop;
  logic                  head_is_last;

  fallthrough_small_fifo #(
    .WIDTH          (FIFO_WIDTH),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo0 (
    .clk         (clk),
    .reset       (reset),
    .din         ({in0_ctrl, in0_data}),
    .wr_en       (in0_wr),
    .rd_en       (rd_en0),
    .dout        (fifo_dout0),
    .full        (full0),
    .nearly_full (nearly_full0),
    .empty       (empty0)
  );

  fallthrough_small_fifo #(
    .WIDTH          (FIFO_WIDTH),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo1 (
    .clk         (clk),
    .reset       (reset),
    .din         ({in1_ctrl, in1_data}),
    .wr_en       (in1_wr),
    .rd_en       (rd_en1),
    .dout        (fifo_dout1),
    .full        (full1),
    .nearly_full (nearly_full1),
    .empty       (empty1)
  );

  // Full implies nearly_full; folding it in keeps ready conservative.
  assign in0_rdy = !(nearly_full0 || full0);
  assign in1_rdy = !(nearly_full1 || full1);

  // Head of the granted FIFO and the pop decision
  assign head         = grant ? fifo_dout1 : fifo_dout0;
  assign head_empty   = grant ? empty1 : empty0;
  assign head_ctrl    = head[FIFO_WIDTH-1 -: CTRL_WIDTH];
  assign head_data    = head[DATA_WIDTH-1:0];
  assign pop          = (state == ST_FWD) && out_rdy && !head_empty;
  assign head_is_last = (sub == SUB_BODY) && (head_ctrl != '0);
  assign rd_en0       = pop && !grant;
  assign rd_en1       = pop && grant;

  // Arbitration FSM with registered output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      sub        <= SUB_HDR;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      out_wr     <= 1'b0;
      out_data   <= '0;
      out_ctrl   <= '0;
      busy       <= 1'b0;
      pkt_cnt0   <= '0;
      pkt_cnt1   <= '0;
    end else begin
      out_wr <= pop;
      if (pop) begin
        out_data <= head_data;
        out_ctrl <= head_ctrl;
      end
      case (state)
        ST_IDLE: begin
          if (arb_enable && (!empty0 || !empty1)) begin
            grant <= rr_pick(last_grant, !empty0, !empty1);
            sub   <= SUB_HDR;
            state <= ST_FWD;
            busy  <= 1'b1;
          end
        end
        ST_FWD: begin
          if (pop) begin
            if (head_is_last) begin
              state      <= ST_IDLE;
              busy       <= 1'b0;
              last_grant <= grant;
              if (grant) pkt_cnt1 <= pkt_cnt1 + CNT_WIDTH'(1);
              else       pkt_cnt0 <= pkt_cnt0 + CNT_WIDTH'(1);
            end else if (head_ctrl == '0) begin
              sub <= SUB_BODY;
            end
          end
        end
      endcase
    end
  end

  // Upstream must honour inN_rdy; writing into a full FIFO would drop a word.
  a_in0_no_overflow: assert property (@(posedge clk) disable iff (reset) !(in0_wr && full0));
  a_in1_no_overflow: assert property (@(posedge clk) disable iff (reset) !(in1_wr && full1));

endmodule

// File: tb/tb_ids_input_arbiter.sv
// Scoreboard bench for ids_input_arbiter: directed packets, monitor checks order, timing, counters.
module tb_ids_input_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } word_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in0_data, in1_data, out_data;
  logic [CW-1:0] in0_ctrl, in1_ctrl, out_ctrl;
  logic          in0_wr, in1_wr, in0_rdy, in1_rdy;
  logic          out_wr, out_rdy, arb_enable, busy;
  logic [31:0]   pkt_cnt0, pkt_cnt1;

  int            vectors = 0;
  int            errors  = 0;
  int            cyc     = 0;
  int            n_out   = 0;
  word_t         exp_q[$];
  int            out_cyc_q[$];

  ids_input_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .in0_data   (in0_data),
    .in0_ctrl   (in0_ctrl),
    .in0_wr     (in0_wr),
    .in0_rdy    (in0_rdy),
    .in1_data   (in1_data),
    .in1_ctrl   (in1_ctrl),
    .in1_wr     (in1_wr),
    .in1_rdy    (in1_rdy),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .out_wr     (out_wr),
    .out_rdy    (out_rdy),
    .arb_enable (arb_enable),
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic word_t mkword(input int port, input int pkt, input int idx, input int n);
    word_t w;
    w.ctrl = (idx == 0) ? 8'hFF : ((idx == n - 1) ? 8'h01 : 8'h00);
    w.data = 64'h5A00_0000_0000_0000 | (64'(port) << 40) | (64'(pkt) << 20) | 64'(idx);
    return w;
  endfunction

  task automatic push_pkt(input int port, input int pkt, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mkword(port, pkt, i, n));
  endtask

  // Monitor: every emitted word is compared against the head of the expected queue
  always @(negedge clk) begin
    word_t e;
    if (!reset && out_wr) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_word: got ctrl %h data %h expected none (cycle %0d)", out_ctrl, out_data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
        check("out_data", out_data, e.data);
      end
      out_cyc_q.push_back(cyc);
      n_out++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writes one packet into a port, honouring its ready; abandons the packet on reset.
  task automatic send_pkt(input int port, input int pkt, input int n);
    for (int i = 0; i < n; i++) begin
      int    guard;
      word_t w;
      guard = 0;
      w = mkword(port, pkt, i, n);
      if (reset) return;
      while (!(port == 0 ? in0_rdy : in1_rdy) && !reset && guard < 200) begin
        tick();
        guard++;
      end
      if (guard >= 200) begin
        vectors++;
        errors++;
        $display("FAIL drv_timeout: port %0d stuck not ready, got 0 expected 1", port);
        return;
      end
      if (reset) return;
      if (port == 0) begin
        in0_ctrl = w.ctrl; in0_data = w.data; in0_wr = 1'b1;
      end else begin
        in1_ctrl = w.ctrl; in1_data = w.data; in1_wr = 1'b1;
      end
      tick();
      if (port == 0) in0_wr = 1'b0;
      else           in1_wr = 1'b0;
    end
  endtask

  task automatic wait_outputs(input int target, input int budget, input string name);
    int b;
    b = 0;
    while (n_out < target && b < budget) begin
      tick();
      b++;
    end
    if (n_out < target) begin
      vectors++;
      errors++;
      $display("FAIL %s_timeout: got %0d words expected %0d", name, n_out, target);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in0_wr = 1'b0;
    in1_wr = 1'b0;
    out_rdy = 1'b1;
    arb_enable = 1'b1;
    tick();
    tick();
    exp_q.delete();
    out_cyc_q.delete();
    n_out = 0;
    reset = 1'b0;
  endtask

  initial begin
    int t0, gaps, gap_len, base;
    reset = 1'b1;
    in0_data = '0; in0_ctrl = '0; in0_wr = 1'b0;
    in1_data = '0; in1_ctrl = '0; in1_wr = 1'b0;
    out_rdy = 1'b1;
    arb_enable = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_wr", 64'(out_wr), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cnt0", 64'(pkt_cnt0), 64'd0);
    check("rst_cnt1", 64'(pkt_cnt1), 64'd0);
    check("rst_in0_rdy", 64'(in0_rdy), 64'd1);
    check("rst_in1_rdy", 64'(in1_rdy), 64'd1);

    // Single 5-word packet: latency 3, contiguous, counted
    tick();
    push_pkt(0, 1, 5);
    t0 = cyc;
    send_pkt(0, 1, 5);
    wait_outputs(5, 50, "single");
    tick();
    check("single_latency", 64'(out_cyc_q[0] - t0), 64'd3);
    check("single_contig", 64'(out_cyc_q[4] - out_cyc_q[0]), 64'd4);
    check("single_cnt0", 64'(pkt_cnt0), 64'd1);
    check("single_busy_after", 64'(busy), 64'd0);

    // Both ports loaded together: port 0 first, one-cycle gap, then port 1
    do_reset();
    push_pkt(0, 2, 3);
    push_pkt(1, 2, 3);
    fork
      send_pkt(0, 2, 3);
      send_pkt(1, 2, 3);
    join
    wait_outputs(6, 50, "both");
    tick();
    check("both_gap", 64'(out_cyc_q[3] - out_cyc_q[2]), 64'd2);
    check("both_cnt0", 64'(pkt_cnt0), 64'd1);
    check("both_cnt1", 64'(pkt_cnt1), 64'd1);

    // Three packets per port back to back: strict alternation
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push_pkt(0, 10 + k, 4);
      push_pkt(1, 10 + k, 4);
    end
    fork
      begin
        for (int k = 0; k < 3; k++) send_pkt(0, 10 + k, 4);
      end
      begin
        for (int k = 0; k < 3; k++) send_pkt(1, 10 + k, 4);
      end
    join
    wait_outputs(24, 400, "rr");
    tick();
    check("rr_cnt0", 64'(pkt_cnt0), 64'd3);
    check("rr_cnt1", 64'(pkt_cnt1), 64'd3);

    // Backpressure: out_rdy low for 4 cycles mid-packet
    do_reset();
    push_pkt(0, 20, 8);
    fork
      send_pkt(0, 20, 8);
      begin
        wait_outputs(2, 50, "stall_pre");
        out_rdy = 1'b0;
        repeat (4) tick();
        out_rdy = 1'b1;
      end
    join
    wait_outputs(8, 60, "stall");
    tick();
    gaps = 0;
    gap_len = 0;
    for (int i = 1; i < out_cyc_q.size(); i++) begin
      if (out_cyc_q[i] - out_cyc_q[i-1] != 1) begin
        gaps++;
        gap_len = out_cyc_q[i] - out_cyc_q[i-1];
      end
    end
    check("stall_gap_count", 64'(gaps), 64'd1);
    check("stall_gap_len", 64'(gap_len), 64'd5);
    check("stall_words", 64'(n_out), 64'd8);
    check("stall_q_empty", 64'(exp_q.size()), 64'd0);

    // arb_enable dropped mid-packet: packet completes, then no grant until re-enabled
    do_reset();
    push_pkt(0, 30, 5);
    push_pkt(1, 30, 3);
    fork
      send_pkt(0, 30, 5);
      send_pkt(1, 30, 3);
      begin
        wait_outputs(2, 50, "dis_pre");
        arb_enable = 1'b0;
      end
    join
    wait_outputs(5, 50, "dis_pkt");
    repeat (20) tick();
    check("dis_words_held", 64'(n_out), 64'd5);
    check("dis_busy", 64'(busy), 64'd0);
    check("dis_cnt1", 64'(pkt_cnt1), 64'd0);
    arb_enable = 1'b1;
    wait_outputs(8, 50, "dis_resume");
    tick();
    check("dis_resume_cnt1", 64'(pkt_cnt1), 64'd1);

    // Counter wrap via backdoor preset
    do_reset();
    tick();
    force dut.pkt_cnt0 = 32'hFFFF_FFFF;
    tick();
    release dut.pkt_cnt0;
    tick();
    check("wrap_preset", 64'(pkt_cnt0), 64'hFFFF_FFFF);
    push_pkt(0, 40, 3);
    send_pkt(0, 40, 3);
    wait_outputs(3, 50, "wrap");
    tick();
    check("wrap_cnt0", 64'(pkt_cnt0), 64'd0);
    check("wrap_cnt1", 64'(pkt_cnt1), 64'd0);

    // Reset mid-packet: output stops next cycle, partial packet discarded
    push_pkt(0, 50, 8);
    pkt_cnt_note: begin
      base = n_out;
      fork
        send_pkt(0, 50, 8);
        begin
          wait_outputs(base + 2, 50, "mid_pre");
          reset = 1'b1;
        end
      join
    end
    in0_wr = 1'b0;
    @(negedge clk);
    check("mid_rst_out_wr", 64'(out_wr), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_cnt0", 64'(pkt_cnt0), 64'd0);
    tick();
    exp_q.delete();
    base = n_out;
    reset = 1'b0;
    repeat (15) tick();
    check("mid_no_more_words", 64'(n_out - base), 64'd0);
    check("mid_in0_rdy", 64'(in0_rdy), 64'd1);
    check("mid_in1_rdy", 64'(in1_rdy), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
